crp16_alu_adder_pipe: RTL and testbench
=======================================

Name: crp16_alu_adder_pipe

Overview:
- Parametrised, pipelined successor to the CRP16 16-bit ripple adder/subtractor.
- Splits the carry chain into SEG_W-bit segments, one segment per pipeline stage, so the ALU clock no longer carries a full-width ripple.
- Adds a carry-in operand mode (ADC/SBC), N/Z/C/V flag generation and a valid/ready handshake.
- Sits between the register-read stage and the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width; WIDTH % SEG_W must be 0 (elaboration error otherwise).
- SEG_W, 4, bits added per stage; STAGES = WIDTH/SEG_W = pipeline latency in cycles.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- c_in  in  1  carry input, used by ADC/SBC only.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- r_out  out  WIDTH  result.
- c_out  out  1  carry out of MSB. For SUB/SBC, 1 = no borrow.
- v_out  out  1  signed overflow.
- n_out  out  1  r_out[WIDTH-1].
- z_out  out  1  r_out == 0.

Behaviour:
- Operand B and carry-in per op:
  - inv = op[0]; effective B = y ^ {WIDTH{inv}}.
  - Carry-in = inv for ADD/SUB; c_in for ADC/SBC.
  - SBC computes x + ~y + c_in (ARM borrow convention).
- Pipeline: STAGES register stages, each holding a valid bit, x, effective B, partial result and running carry.
  - Stage k adds bits [k*SEG_W +: SEG_W] using the carry from stage k-1.
  - Stage 0 uses the selected carry-in.
  - Untouched upper bits travel with the beat.
- Global advance: adv = ~out_valid | out_ready.
  - All stages shift together when adv = 1; all hold when adv = 0.
  - in_ready = adv (combinational).
  - Beat accepted when in_valid & in_ready.
  - Bubbles (valid = 0) propagate and are not collapsed.
- Latency: exactly STAGES cycles from acceptance to out_valid with no back-pressure. Throughput is 1 beat/cycle.
- Output register: the last stage drives r_out/c_out/v_out/n_out/z_out. Values hold stable while out_valid & ~out_ready.
  - v_out = (xA[MSB] == B[MSB]) & (r[MSB] != xA[MSB]), using effective B.
  - z_out and n_out are registered from the final result, not derived combinationally after the register.
- Reset (asserted at any time, including mid-stream):
  - All valid bits go to 0 immediately; in-flight beats are discarded.
  - r_out = 0, c_out = 0, v_out = 0, n_out = 0, z_out = 0, out_valid = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Simultaneous events: out_ready and in_valid in the same cycle as a full pipe shifts, accepting the new beat and retiring the old one with no lost cycle.
- Data path registers beyond valid bits need not be reset, but outputs must read 0 while out_valid = 0 after reset.
- Wrap-around: arithmetic is modulo 2^WIDTH; carry is reported in c_out only.

Optional Feature:
- Macro: CRP16_ADDER_SAT_EN.
- When defined: extra input port `sat` (1 bit), captured with the beat.
  - If sat = 1 and the signed result overflows, r_out clamps to 0x7FFF (positive overflow) or 0x8000 (negative) for WIDTH = 16, i.e. signed max/min in general.
  - v_out still reports the overflow.
  - n_out and z_out reflect the clamped value.
  - Latency is unchanged; the clamp is applied in the last stage.
- When undefined: no `sat` port; results always wrap.

Test Plan:
- Defaults (16/4), ADD x=0x1234, y=0x0FFF, out_ready=1 -> 4 cycles later r_out=0x2233, c_out=0, v_out=0, z_out=0, n_out=0.
- SUB x=0x0005, y=0x0005 -> r_out=0x0000, z_out=1, c_out=1. SUB x=0x0000, y=0x0001 -> r_out=0xFFFF, c_out=0, n_out=1.
- ADC x=0xFFFF, y=0x0000, c_in=1 -> r_out=0x0000, c_out=1, z_out=1. ADD x=0x7FFF, y=0x0001 -> r_out=0x8000, v_out=1, n_out=1.
- Back-to-back 8 beats with out_ready held 0 from cycle 6 for 3 cycles:
  - in_ready drops while stalled.
  - Outputs stay stable during the stall.
  - All 8 results emerge in order with no loss or duplication.
- Assert reset with 3 beats in flight -> out_valid=0 and all flags 0 the same cycle; no stale beat appears after release.
- With CRP16_ADDER_SAT_EN, sat=1, ADD 0x7000+0x2000 -> r_out=0x7FFF, v_out=1. SUB 0x8000-0x0001 -> r_out=0x8000, v_out=1.

Source files
------------

// File: rtl/crp16_alu_adder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : crp16_alu_adder_pipe_if
// Purpose  : Operand/result bundle for the CRP16 pipelined adder/subtractor.
//            Carries the operand beat (valid/ready, x, y, op, c_in) and the
//            result beat (valid/ready, r_out plus N/Z/C/V flags).
// Modports : master - producer of operands and consumer of results
//            slave  - the adder pipeline itself
// Options  : CRP16_ADDER_SAT_EN adds the per-beat 'sat' (saturate) bit.
// Revision : 1.0 - initial release
// ============================================================================
interface crp16_alu_adder_pipe_if #(
    parameter int WIDTH = 16
);
    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [1:0]       op;
    logic             c_in;
`ifdef CRP16_ADDER_SAT_EN
    logic             sat;
`endif

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r_out;
    logic             c_out;
    logic             v_out;
    logic             n_out;
    logic             z_out;

`ifdef CRP16_ADDER_SAT_EN
    modport master (
        output in_valid, x, y, op, c_in, sat, out_ready,
        input  in_ready, out_valid, r_out, c_out, v_out, n_out, z_out
    );

    modport slave (
        input  in_valid, x, y, op, c_in, sat, out_ready,
        output in_ready, out_valid, r_out, c_out, v_out, n_out, z_out
    );
`else
    modport master (
        output in_valid, x, y, op, c_in, out_ready,
        input  in_ready, out_valid, r_out, c_out, v_out, n_out, z_out
    );

    modport slave (
        input  in_valid, x, y, op, c_in, out_ready,
        output in_ready, out_valid, r_out, c_out, v_out, n_out, z_out
    );
`endif

endinterface
`default_nettype wire

// File: rtl/crp16_alu_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : crp16_alu_adder_pipe
// Purpose  : Pipelined WIDTH-bit adder/subtractor for the CRP16 ALU. The carry
//            chain is cut into SEG_W-bit segments, one segment per register
//            stage, so the latency is STAGES = WIDTH/SEG_W cycles with a
//            throughput of one beat per cycle.
//            op: 00 ADD (x+y), 01 SUB (x+~y+1), 10 ADC (x+y+c_in),
//                11 SBC (x+~y+c_in). c_out is the raw carry out of the MSB,
//                so for SUB/SBC c_out = 1 means "no borrow".
// Ports    : clock - rising-edge clock
//            reset - asynchronous, active-high reset
//            bus   - crp16_alu_adder_pipe_if.slave (operand/result handshakes,
//                    operands, op, carry-in, result and N/Z/C/V flags)
// Options  : CRP16_ADDER_SAT_EN - adds bus.sat; when set on a beat, a signed
//            overflow clamps the result to the signed max/min.
// Revision : 1.0 - initial release
// ============================================================================
module crp16_alu_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  wire logic               clock,
    input  wire logic               reset,
    crp16_alu_adder_pipe_if.slave   bus
);

    localparam int c_stages = WIDTH / SEG_W;
    localparam int c_last   = c_stages - 1;
    localparam int c_msb    = WIDTH - 1;

    localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};

    // Reject configurations where the segments do not tile the word exactly.
    if ((SEG_W < 1) || (WIDTH % SEG_W != 0)) begin : g_cfg_check
        $error("crp16_alu_adder_pipe: WIDTH must be a multiple of SEG_W");
    end

    // ------------------------------------------------------------------------
    // Pipeline registers. Entry k holds the beat after segment k was added;
    // entry c_last is the output register.
    // ------------------------------------------------------------------------
    logic             r_vld [c_stages];
    logic [WIDTH-1:0] r_a   [c_stages];   // operand A travelling with the beat
    logic [WIDTH-1:0] r_b   [c_stages];   // effective operand B
    logic [WIDTH-1:0] r_res [c_stages];   // partial result (final at c_last)
    logic             r_cy  [c_stages];   // running carry out of segment k
`ifdef CRP16_ADDER_SAT_EN
    logic             r_sat [c_stages];
`endif
    logic             r_v;
    logic             r_n;
    logic             r_z;

    // ------------------------------------------------------------------------
    // Combinational stage inputs/outputs
    // ------------------------------------------------------------------------
    logic             w_adv;
    logic             w_inv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin0;

    logic             w_vld_in [c_stages];
    logic [WIDTH-1:0] w_a_in   [c_stages];
    logic [WIDTH-1:0] w_b_in   [c_stages];
    logic [WIDTH-1:0] w_res_in [c_stages];
    logic             w_cy_in  [c_stages];
`ifdef CRP16_ADDER_SAT_EN
    logic             w_sat_in [c_stages];
`endif

    logic [SEG_W:0]   w_seg     [c_stages];
    logic [WIDTH-1:0] w_res_out [c_stages];
    logic             w_cy_out  [c_stages];

    logic             w_ovf;
    logic [WIDTH-1:0] w_final;
    logic             w_n;
    logic             w_z;

    // Every stage moves together: the pipe only stalls when a finished
    // result is sitting in the output register and nobody takes it.
    assign w_adv = ~r_vld[c_last] | bus.out_ready;

    // Odd ops subtract; ADD/SUB supply their own carry-in (0 / 1), the
    // carry-using ops take it from the c_in operand.
    assign w_inv   = bus.op[0];
    assign w_b_eff = bus.y ^ {WIDTH{w_inv}};
    assign w_cin0  = bus.op[1] ? bus.c_in : w_inv;

    // Stage inputs: stage 0 from the operand port, stage k from register k-1.
    always_comb begin
        w_vld_in[0] = bus.in_valid;
        w_a_in[0]   = bus.x;
        w_b_in[0]   = w_b_eff;
        w_res_in[0] = '0;
        w_cy_in[0]  = w_cin0;
`ifdef CRP16_ADDER_SAT_EN
        w_sat_in[0] = bus.sat;
`endif
        for (int k = 1; k < c_stages; k++) begin
            w_vld_in[k] = r_vld[k-1];
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_res_in[k] = r_res[k-1];
            w_cy_in[k]  = r_cy[k-1];
`ifdef CRP16_ADDER_SAT_EN
            w_sat_in[k] = r_sat[k-1];
`endif
        end
    end

    // Per-stage segment adder: stage k only fills bits [k*SEG_W +: SEG_W].
    always_comb begin
        for (int k = 0; k < c_stages; k++) begin
            w_seg[k] = {1'b0, w_a_in[k][k*SEG_W +: SEG_W]}
                     + {1'b0, w_b_in[k][k*SEG_W +: SEG_W]}
                     + {{SEG_W{1'b0}}, w_cy_in[k]};
            w_res_out[k]                    = w_res_in[k];
            w_res_out[k][k*SEG_W +: SEG_W]  = w_seg[k][SEG_W-1:0];
            w_cy_out[k]                     = w_seg[k][SEG_W];
        end
    end

    // Last stage: overflow from the effective operands, optional clamp, then
    // N/Z taken from the value that is actually registered.
    always_comb begin
        w_ovf   = (w_a_in[c_last][c_msb] == w_b_in[c_last][c_msb]) &
                  (w_res_out[c_last][c_msb] != w_a_in[c_last][c_msb]);
        w_final = w_res_out[c_last];
`ifdef CRP16_ADDER_SAT_EN
        // Both operands share a sign on overflow, so A's sign gives direction.
        if (w_sat_in[c_last] && w_ovf) begin
            w_final = w_a_in[c_last][c_msb] ? c_smin : c_smax;
        end
`endif
        w_n = w_final[c_msb];
        w_z = (w_final == '0);
    end

    // ------------------------------------------------------------------------
    // Registers. Data only loads with a valid beat, so after reset the output
    // register keeps reading zero until the first real result arrives, and
    // bubbles leave the previous data in place.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < c_stages; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_res[k] <= '0;
                r_cy[k]  <= 1'b0;
`ifdef CRP16_ADDER_SAT_EN
                r_sat[k] <= 1'b0;
`endif
            end
            r_v <= 1'b0;
            r_n <= 1'b0;
            r_z <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < c_stages; k++) begin
                r_vld[k] <= w_vld_in[k];
                if (w_vld_in[k]) begin
                    r_a[k]   <= w_a_in[k];
                    r_b[k]   <= w_b_in[k];
                    r_res[k] <= (k == c_last) ? w_final : w_res_out[k];
                    r_cy[k]  <= w_cy_out[k];
`ifdef CRP16_ADDER_SAT_EN
                    r_sat[k] <= w_sat_in[k];
`endif
                end
            end
            if (w_vld_in[c_last]) begin
                r_v <= w_ovf;
                r_n <= w_n;
                r_z <= w_z;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[c_last];
    assign bus.r_out     = r_res[c_last];
    assign bus.c_out     = r_cy[c_last];
    assign bus.v_out     = r_v;
    assign bus.n_out     = r_n;
    assign bus.z_out     = r_z;

endmodule
`default_nettype wire

// File: tb/tb_crp16_alu_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_crp16_alu_adder_pipe
// Purpose  : Self-checking bench for crp16_alu_adder_pipe (16-bit, 4-bit
//            segments). Directed vector table plus streaming/stall and
//            mid-stream reset sequences. Saturation vectors are added when
//            CRP16_ADDER_SAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crp16_alu_adder_pipe;

    localparam int W   = 16;
    localparam int STG = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    crp16_alu_adder_pipe_if #(.WIDTH(W)) bus ();

    crp16_alu_adder_pipe #(
        .WIDTH (W),
        .SEG_W (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic         sat;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         n;
        logic         z;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic cin, input logic sat, input logic [W-1:0] r,
                           input logic c, input logic v, input logic n, input logic z);
        vec_t t;
        t.op = op; t.x = x; t.y = y; t.cin = cin; t.sat = sat;
        t.r = r; t.c = c; t.v = v; t.n = n; t.z = z;
        vecs.push_back(t);
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.op        = 2'b00;
        bus.c_in      = 1'b0;
`ifdef CRP16_ADDER_SAT_EN
        bus.sat       = 1'b0;
`endif
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_q[$];
        int lat;

        drive_idle();

        //                op     x        y        cin  sat  r        c  v  n  z
        add_vec(2'b00, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 0, 0, 0, 0);
        add_vec(2'b01, 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0000, 1, 0, 0, 1);
        add_vec(2'b01, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 0, 0, 1, 0);
        add_vec(2'b10, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1, 0, 0, 1);
        add_vec(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 0, 1, 1, 0);
        add_vec(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1, 0, 0, 1);
        add_vec(2'b00, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002, 0, 0, 0, 0);
        add_vec(2'b10, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 0, 0, 0, 0);
        add_vec(2'b11, 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0001, 1, 0, 0, 0);
        add_vec(2'b11, 16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1, 0, 0, 0);
        add_vec(2'b01, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1, 1, 0, 0);
`ifdef CRP16_ADDER_SAT_EN
        add_vec(2'b00, 16'h7000, 16'h2000, 1'b0, 1'b1, 16'h7FFF, 0, 1, 0, 0);
        add_vec(2'b01, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1, 1, 1, 0);
        add_vec(2'b00, 16'h1000, 16'h2000, 1'b0, 1'b1, 16'h3000, 0, 0, 0, 0);
`endif

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        check("rst.out_valid", 32'(bus.out_valid), 32'h0);
        check("rst.r_out",     32'(bus.r_out),     32'h0);
        check("rst.c_out",     32'(bus.c_out),     32'h0);
        check("rst.v_out",     32'(bus.v_out),     32'h0);
        check("rst.n_out",     32'(bus.n_out),     32'h0);
        check("rst.z_out",     32'(bus.z_out),     32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("rst.in_ready", 32'(bus.in_ready), 32'h1);

        // ---------------- vector table, one beat at a time ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.op       = vecs[i].op;
            bus.x        = vecs[i].x;
            bus.y        = vecs[i].y;
            bus.c_in     = vecs[i].cin;
`ifdef CRP16_ADDER_SAT_EN
            bus.sat      = vecs[i].sat;
`endif
            @(negedge clock);
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < 12) begin
                @(negedge clock);
                lat++;
            end
            check($sformatf("v%0d.latency", i), 32'(lat),           32'(STG));
            check($sformatf("v%0d.r_out", i),   32'(bus.r_out),     32'(vecs[i].r));
            check($sformatf("v%0d.c_out", i),   32'(bus.c_out),     32'(vecs[i].c));
            check($sformatf("v%0d.v_out", i),   32'(bus.v_out),     32'(vecs[i].v));
            check($sformatf("v%0d.n_out", i),   32'(bus.n_out),     32'(vecs[i].n));
            check($sformatf("v%0d.z_out", i),   32'(bus.z_out),     32'(vecs[i].z));
        end

        // ---------------- 8 back-to-back beats with a 3-cycle stall ----------------
        begin
            int sent = 0, got = 0, cyc = 0;
            bit saw_stall = 0;
            bit held = 0;
            logic [W-1:0] held_r;

            for (int i = 0; i < 8; i++)
                exp_q.push_back(16'(16'h1111 * (i + 1) + 16'h0F0F + i));

            while (got < 8 && cyc < 60) begin
                @(negedge clock);
                bus.out_ready = !(cyc >= 6 && cyc <= 8);
                bus.in_valid  = (sent < 8);
                bus.op        = 2'b00;
                bus.c_in      = 1'b0;
`ifdef CRP16_ADDER_SAT_EN
                bus.sat       = 1'b0;
`endif
                bus.x         = 16'(16'h1111 * (sent + 1));
                bus.y         = 16'(16'h0F0F + sent);
                #1;
                if (bus.out_valid && !bus.out_ready) begin
                    check("stall.in_ready", 32'(bus.in_ready), 32'h0);
                    if (held) check("stall.hold", 32'(bus.r_out), 32'(held_r));
                    held_r    = bus.r_out;
                    held      = 1;
                    saw_stall = 1;
                end else if (bus.out_valid) begin
                    check($sformatf("stream.r%0d", got), 32'(bus.r_out), 32'(exp_q[got]));
                    got++;
                    held = 0;
                end
                if (bus.in_valid && bus.in_ready) sent++;
                cyc++;
            end
            check("stream.count", 32'(got), 32'd8);
            check("stream.sent", 32'(sent), 32'd8);
            check("stream.stalled", 32'(saw_stall), 32'h1);
            @(negedge clock);
            drive_idle();
            repeat (STG + 2) @(negedge clock);
            check("stream.no_dup", 32'(bus.out_valid), 32'h0);
        end

        // ---------------- reset with beats in flight ----------------
        begin
            int stale = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                bus.in_valid = 1'b1;
                bus.op       = 2'b00;
                bus.x        = 16'h7FFF;
                bus.y        = 16'h0001;
            end
            @(negedge clock);
            bus.in_valid = 1'b0;
            #1;
            check("midrst.pre_valid", 32'(bus.out_valid), 32'h1);
            check("midrst.pre_n",     32'(bus.n_out),     32'h1);
            reset = 1'b1;
            #1;
            check("midrst.out_valid", 32'(bus.out_valid), 32'h0);
            check("midrst.r_out",     32'(bus.r_out),     32'h0);
            check("midrst.flags",     32'({bus.c_out, bus.v_out, bus.n_out, bus.z_out}), 32'h0);
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            check("midrst.in_ready", 32'(bus.in_ready), 32'h1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                if (bus.out_valid) stale++;
            end
            check("midrst.stale", 32'(stale), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
